// File: rtl/user_key_input.sv
// user_key_input: board switch / push-button front end with a bus register window.
// Synchronizes raw dip_switch and user_key_n, debounces them on a slow sample tick,
// captures key presses into pending bits, and raises a masked level interrupt.
//
// Ports:
//   clk, reset     - system clock; synchronous active-high reset
//   WE, Addr, Din  - bus write enable, word address (byte addr = {Addr,2'b00}), write data
//   Dout           - bus read data, combinational from Addr
//   dip_switch     - raw switches, asynchronous, active-high
//   user_key_n     - raw push buttons, asynchronous, active-low
//   irq            - level interrupt, |(pend & mask)
//
// Register map (byte addresses):
//   0x7F40 R   debounced switches
//   0x7F44 R   {24'h0, debounced keys}
//   0x7F48 RW  {24'h0, pend}; writing 1 clears a bit, a coincident key press wins
//   0x7F4C RW  {24'h0, mask}

module user_key_input #(
  parameter int TICK_DIV = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:2] Addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [31:0] dip_switch,
  input  logic [7:0]  user_key_n,
  output logic        irq
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [31:0] ADDR_SW   = 32'h0000_7F40;
  localparam logic [31:0] ADDR_KEY  = 32'h0000_7F44;
  localparam logic [31:0] ADDR_PEND = 32'h0000_7F48;
  localparam logic [31:0] ADDR_MASK = 32'h0000_7F4C;

  // Bits [31:0] are switches, [39:32] are keys (already inverted to active-high).
  localparam int NB = 40;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [NB-1:0] h0_q, h1_q, h2_q;
  logic [NB-1:0] h0_d, h1_d, h2_d;
  logic [NB-1:0] deb_q, deb_d;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    key_rise;
  logic [7:0]    pend_clr;
  logic [NB-1:0] agree1, agree0;
  logic [31:0]   byte_addr;
  logic          unused_din;

  assign raw        = {~user_key_n, dip_switch};
  assign byte_addr  = {Addr, 2'b00};
  assign unused_din = ^Din[31:8];

  // Prescaler: tick marks the last count of each sample period.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Debounce looks at the history as it will be after this tick's shift, so the
  // third agreeing sample updates the output on the same edge it is taken.
  always_comb begin
    h0_d   = h0_q;
    h1_d   = h1_q;
    h2_d   = h2_q;
    deb_d  = deb_q;
    agree1 = '0;
    agree0 = '0;
    if (tick) begin
      h0_d   = sync2_q;
      h1_d   = h0_q;
      h2_d   = h1_q;
      agree1 = h0_d & h1_d & h2_d;
      agree0 = ~(h0_d | h1_d | h2_d);
      deb_d  = (deb_q & ~agree0) | agree1;
    end
  end

  // Pending bits: a debounced press sets, W1C clears; set is applied last so it wins.
  assign key_rise = deb_d[39:32] & ~deb_q[39:32];
  assign pend_clr = (WE && byte_addr == ADDR_PEND) ? Din[7:0] : 8'h00;
  assign pend_d   = (pend_q & ~pend_clr) | key_rise;
  assign mask_d   = (WE && byte_addr == ADDR_MASK) ? Din[7:0] : mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      deb_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  assign irq = |(pend_q & mask_q);

  always_comb begin
    Dout = 32'h0;
    case (byte_addr)
      ADDR_SW:   Dout = deb_q[31:0];
      ADDR_KEY:  Dout = {24'h0, deb_q[39:32]};
      ADDR_PEND: Dout = {24'h0, pend_q};
      ADDR_MASK: Dout = {24'h0, mask_q};
      default:   Dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_user_key_input.sv
// Directed bench for user_key_input with TICK_DIV=4.
// Inputs change and outputs are sampled on the falling edge; ecount counts
// rising edges since reset release, so tick edges are the multiples of 4.

module tb_user_key_input;

  localparam logic [31:0] A_SW   = 32'h0000_7F40;
  localparam logic [31:0] A_KEY  = 32'h0000_7F44;
  localparam logic [31:0] A_PEND = 32'h0000_7F48;
  localparam logic [31:0] A_MASK = 32'h0000_7F4C;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:2] Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [31:0] dip_switch;
  logic [7:0]  user_key_n;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  user_key_input #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .WE         (WE),
    .Addr       (Addr),
    .Din        (Din),
    .Dout       (Dout),
    .dip_switch (dip_switch),
    .user_key_n (user_key_n),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a[31:2];
    #1;
    d = Dout;
  endtask

  // Called on a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] dat);
    WE   = 1'b1;
    Addr = a[31:2];
    Din  = dat;
    @(negedge clk);
    WE   = 1'b0;
    Din  = 32'h0;
  endtask

  task automatic wait_to(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  task automatic wait_key(input int b, input logic v, input int maxc, output int took);
    logic [31:0] d;
    took = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      rd(A_KEY, d);
      if (d[b] === v) begin
        took = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          took;
    int          e;
    bit          seen;
    int          n;
    int          t0;

    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    dip_switch = 32'h0; user_key_n = 8'hFF;
    repeat (3) @(negedge clk);

    rd(A_SW, d);   chk("rst_sw", d, 32'h0);
    rd(A_KEY, d);  chk("rst_key", d, 32'h0);
    rd(A_PEND, d); chk("rst_pend", d, 32'h0);
    rd(A_MASK, d); chk("rst_mask", d, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Switch latency window: 0 before edge 10, final value by edge 14.
    reset = 1'b0;
    dip_switch = 32'hA5A5_0F0F;
    wait_to(9);
    rd(A_SW, d); chk("sw_early", d, 32'h0);
    wait_to(14);
    rd(A_SW, d); chk("sw_late", d, 32'hA5A5_0F0F);

    // Read-only registers ignore writes; upper address bits are decoded.
    wr(A_SW, 32'hFFFF_FFFF);
    rd(A_SW, d); chk("sw_wr_ign", d, 32'hA5A5_0F0F);
    wr(A_KEY, 32'hFFFF_FFFF);
    rd(A_KEY, d); chk("key_wr_ign", d, 32'h0);
    rd(32'h0001_7F40, d); chk("unmapped", d, 32'h0);

    // 3-cycle glitch on key 3 is rejected.
    user_key_n[3] = 1'b0;
    repeat (3) @(negedge clk);
    user_key_n[3] = 1'b1;
    repeat (20) @(negedge clk);
    rd(A_KEY, d);  chk("glitch_key", d, 32'h0);
    rd(A_PEND, d); chk("glitch_pend", d, 32'h0);

    // Mask write keeps only Din[7:0]; held key 3 debounces, pends, interrupts.
    wr(A_MASK, 32'hFFFF_FF08);
    rd(A_MASK, d); chk("mask_rd", d, 32'h8);
    user_key_n[3] = 1'b0;
    seen = 1'b0;
    e = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      rd(A_KEY, d);
      if (!seen && d == 32'h8) begin
        seen = 1'b1;
        e = c;
        rd(A_PEND, d); chk("pend_with_key", d, 32'h8);
        chk("irq_set", 32'(irq), 32'h1);
      end
    end
    chk("key3_seen", 32'(seen), 32'h1);
    chk("key3_latency", 32'(e >= 10 && e <= 14), 32'h1);

    // W1C clears pend and irq; release does not re-pend.
    wr(A_PEND, 32'h8);
    rd(A_PEND, d); chk("w1c_pend", d, 32'h0);
    chk("w1c_irq", 32'(irq), 32'h0);
    user_key_n[3] = 1'b1;
    wait_key(3, 1'b0, 20, took);
    chk("key3_rel", 32'(took > 0), 32'h1);
    repeat (4) @(negedge clk);
    rd(A_PEND, d); chk("rel_no_pend", d, 32'h0);

    // Key 0: press/release leaves pend[0]=1 (masked off, so no irq).
    user_key_n[0] = 1'b0;
    wait_key(0, 1'b1, 20, took);
    chk("key0_press1", 32'(took > 0), 32'h1);
    user_key_n[0] = 1'b1;
    wait_key(0, 1'b0, 20, took);
    chk("key0_rel1", 32'(took > 0), 32'h1);
    rd(A_PEND, d); chk("pend0_held", d, 32'h1);
    chk("irq_masked", 32'(irq), 32'h0);

    // Second press: W1C of bit 0 lands on the debounce edge; set must win.
    n = ecount;
    user_key_n[0] = 1'b0;
    t0 = ((n + 6) / 4) * 4;
    wait_to(t0 + 7);
    wr(A_PEND, 32'h1);
    rd(A_KEY, d);  chk("key0_at_w1c", d, 32'h1);
    rd(A_PEND, d); chk("set_wins", d, 32'h1);
    wr(A_MASK, 32'h1);
    chk("irq_mask0", 32'(irq), 32'h1);

    // Reset while key 5 is half-debounced.
    user_key_n = 8'hDF;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(A_SW, d);   chk("rst2_sw", d, 32'h0);
    rd(A_KEY, d);  chk("rst2_key", d, 32'h0);
    rd(A_PEND, d); chk("rst2_pend", d, 32'h0);
    rd(A_MASK, d); chk("rst2_mask", d, 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    wait_to(11);
    rd(A_KEY, d);  chk("key5_not_early", d, 32'h0);
    wait_to(14);
    rd(A_KEY, d);  chk("key5_fresh", d, 32'h20);
    rd(A_PEND, d); chk("key5_pend", d, 32'h20);
    chk("key5_irq_masked", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
